// File: rtl/booth_sched_pkg.sv
// Shared types and default sizing for the Booth multiplier scheduler.
// Optional flush port is enabled by defining BOOTH_SCHED_FLUSH_EN.
package booth_sched_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_NUM_REQ    = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub of m then arithmetic shift of {A,Q,q-1}.
// Purely combinational.
module booth_step
   import booth_sched_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH:0]   a,
   input  logic [DATA_WIDTH-1:0] q,
   input  logic                  q_minus_one,
   input  logic [DATA_WIDTH-1:0] m,
   output logic [DATA_WIDTH:0]   a_next,
   output logic [DATA_WIDTH-1:0] q_next,
   output logic                  q_minus_one_next
);

   logic [DATA_WIDTH:0] m_ext;
   logic [DATA_WIDTH:0] sum;

   // Extra A bit keeps A - m exact when m is the most-negative value
   assign m_ext = {m[DATA_WIDTH-1], m};

   always_comb begin
      sum = a;
      case ({q[0], q_minus_one})
         2'b10:   sum = a - m_ext;
         2'b01:   sum = a + m_ext;
         default: sum = a;
      endcase
   end

   assign a_next           = {sum[DATA_WIDTH], sum[DATA_WIDTH:1]};
   assign q_next           = {sum[0], q[DATA_WIDTH-1:1]};
   assign q_minus_one_next = q[0];

endmodule

// File: rtl/booth_mul_scheduler.sv
// Round-robin shared sequential Booth multiplier (IDLE/RUN/DONE).
// Define BOOTH_SCHED_FLUSH_EN to add the flush input.
module booth_mul_scheduler
   import booth_sched_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REQ    = DEF_NUM_REQ,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_m,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_q,
`ifdef BOOTH_SCHED_FLUSH_EN
   input  logic                                 flush,
`endif
   output logic                                 rsp_valid,
   input  logic                                 rsp_ready,
   output logic [ID_W-1:0]                      rsp_id,
   output logic [2*DATA_WIDTH-1:0]              rsp_result,
   output logic                                 busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH:0]   acc;
   logic [DATA_WIDTH:0]   acc_step;
   logic [DATA_WIDTH-1:0] mq;
   logic [DATA_WIDTH-1:0] mq_step;
   logic [DATA_WIDTH-1:0] mcand;
   logic                  qm1;
   logic                  qm1_step;
   logic [CNT_W-1:0]      step_cnt;
   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       owner;
   logic [ID_W-1:0]       grant_id;
   logic                  grant_any;
   logic [NUM_REQ-1:0]    grant_vec;
   logic                  last_step;
   logic                  flush_c;

`ifdef BOOTH_SCHED_FLUSH_EN
   assign flush_c = flush;
`else
   assign flush_c = 1'b0;
`endif

   assign last_step = (step_cnt == CNT_W'(DATA_WIDTH - 1));

   always_comb begin : grant_search
      logic [ID_W:0] idx;
      idx       = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      grant_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
         if (idx >= (ID_W+1)'(NUM_REQ)) begin
            idx = idx - (ID_W+1)'(NUM_REQ);
         end
         if (!grant_any && req_valid[idx[ID_W-1:0]]) begin
            grant_any = 1'b1;
            grant_id  = idx[ID_W-1:0];
         end
      end
      // Reset is folded in so req_ready reads 0 while rst_n is low
      if (state != IDLE || flush_c || !rst_n) begin
         grant_any = 1'b0;
      end
      if (grant_any) begin
         grant_vec[grant_id] = 1'b1;
      end
   end

   booth_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .a                (acc),
      .q                (mq),
      .q_minus_one      (qm1),
      .m                (mcand),
      .a_next           (acc_step),
      .q_next           (mq_step),
      .q_minus_one_next (qm1_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_any) state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_c) begin
         state_next = IDLE;
      end
   end

   always_comb begin
      req_ready  = grant_vec;
      busy       = (state != IDLE);
      rsp_valid  = 1'b0;
      rsp_id     = '0;
      rsp_result = '0;
      if (state == DONE) begin
         rsp_valid  = 1'b1;
         rsp_id     = owner;
         rsp_result = {acc[DATA_WIDTH-1:0], mq};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         mq       <= '0;
         mcand    <= '0;
         qm1      <= 1'b0;
         step_cnt <= '0;
         rr_ptr   <= '0;
         owner    <= '0;
      end else if (grant_any) begin
         acc      <= '0;
         mq       <= req_q[grant_id];
         mcand    <= req_m[grant_id];
         qm1      <= 1'b0;
         step_cnt <= '0;
         owner    <= grant_id;
         rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end else if (state == RUN) begin
         acc      <= acc_step;
         mq       <= mq_step;
         qm1      <= qm1_step;
         step_cnt <= step_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Randomized + directed bench for booth_mul_scheduler against a transaction model.
// Exercises flush when BOOTH_SCHED_FLUSH_EN is defined.
module tb_booth_mul_scheduler;

   localparam int W  = 8;
   localparam int N  = 2;
   localparam int IW = 1;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N-1:0][W-1:0] req_m;
   logic [N-1:0][W-1:0] req_q;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IW-1:0]      rsp_id;
   logic [2*W-1:0]     rsp_result;
   logic               busy;
`ifdef BOOTH_SCHED_FLUSH_EN
   logic               flush = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   booth_mul_scheduler #(
      .DATA_WIDTH (W),
      .NUM_REQ    (N)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_m      (req_m),
      .req_q      (req_q),
`ifdef BOOTH_SCHED_FLUSH_EN
      .flush      (flush),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Transaction-level model: one job in flight, result due W+1 cycles after grant
   bit             m_pend = 0;
   int             m_due  = 0;
   int             m_rr   = 0;
   int             m_id   = 0;
   logic [2*W-1:0] m_res  = '0;

   always @(negedge clk) begin : model
      logic signed [2*W-1:0] sa, sb;
      logic [N-1:0] e_ready;
      bit   fl, e_valid;
      int   g, j;
      if (!rst_n) begin
         chk("reset_outs", {req_ready, rsp_valid, rsp_result, rsp_id, busy}, 0);
         m_pend = 0;
         m_rr   = 0;
      end else begin
         fl = 0;
`ifdef BOOTH_SCHED_FLUSH_EN
         fl = flush;
`endif
         g = -1;
         if (!m_pend && !fl) begin
            for (int k = 0; k < N; k++) begin
               j = (m_rr + k) % N;
               if (g < 0 && req_valid[j]) g = j;
            end
         end
         e_valid = m_pend && (cyc >= m_due);
         e_ready = '0;
         if (g >= 0) e_ready[g] = 1'b1;
         chk("req_ready", req_ready, e_ready);
         chk("rsp_valid", rsp_valid, e_valid);
         chk("busy", busy, m_pend);
         chk("rsp_result", rsp_result, e_valid ? m_res : '0);
         chk("rsp_id", rsp_id, e_valid ? m_id : 0);
         if (fl) begin
            m_pend = 0;
         end else if (g >= 0) begin
            sa     = $signed(req_m[g]);
            sb     = $signed(req_q[g]);
            m_res  = sa * sb;
            m_id   = g;
            m_due  = cyc + W + 1;
            m_rr   = (g + 1) % N;
            m_pend = 1;
         end else if (e_valid && rsp_ready) begin
            m_pend = 0;
         end
      end
   end

   task automatic wait_any_grant(output int who, output int gc);
      who = -1;
      gc  = 0;
      for (int k = 0; k < 60 && who < 0; k++) begin
         @(negedge clk);
         for (int r = 0; r < N; r++) begin
            if (req_ready[r]) begin
               who = r;
               gc  = cyc;
            end
         end
      end
      if (who < 0) chk("grant_timeout", 0, 1);
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         if (rsp_valid) ok = 1;
      end
   endtask

   task automatic op(input int r, input logic [W-1:0] m,
                     input logic [W-1:0] q, input logic [2*W-1:0] exp,
                     input string tag);
      int who, gc;
      bit ok;
      @(posedge clk);
      #1;
      req_m[r]     = m;
      req_q[r]     = q;
      req_valid[r] = 1'b1;
      wait_any_grant(who, gc);
      chk({tag, "_grant_id"}, who, r);
      @(posedge clk);
      #1 req_valid[r] = 1'b0;
      wait_rsp(ok);
      chk({tag, "_rsp_seen"}, ok, 1);
      chk({tag, "_latency"}, cyc - gc, W + 1);
      chk({tag, "_result"}, rsp_result, exp);
      chk({tag, "_id"}, rsp_id, r);
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 6))
         0:       v = {1'b1, {(W-1){1'b0}}};
         1:       v = {1'b0, {(W-1){1'b1}}};
         2:       v = '1;
         3:       v = '0;
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   initial begin : stim
      int seq[$];
      int who, gc;
      bit ok;
      logic [2*W-1:0] hold_res;
      logic [IW-1:0]  hold_id;
      req_valid = '0;
      req_m     = '0;
      req_q     = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      op(0, 8'd7,   8'd3,   16'h0015, "m7q3");
      op(1, 8'h80,  8'h80,  16'h4000, "min_min");
      op(0, 8'h7F,  8'h80,  16'hC080, "max_min");
      op(1, 8'h00,  8'hFF,  16'h0000, "zero_neg1");

      // Fresh pointer, both requesters contending for three operations
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      req_m     = {8'd5, 8'd9};
      req_q     = {8'd11, 8'hF3};
      req_valid = 2'b11;
      for (int k = 0; k < 100 && seq.size() < 3; k++) begin
         @(negedge clk);
         chk("ready_onehot0", $onehot0(req_ready), 1);
         for (int r = 0; r < N; r++) if (req_ready[r]) seq.push_back(r);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      chk("rr_count", seq.size(), 3);
      if (seq.size() == 3) begin
         chk("rr_g0", seq[0], 0);
         chk("rr_g1", seq[1], 1);
         chk("rr_g2", seq[2], 0);
      end
      repeat (W + 4) @(posedge clk);

      // Back-pressure in DONE with another requester waiting
      #1;
      rsp_ready    = 1'b0;
      req_m[0]     = 8'h9C;
      req_q[0]     = 8'h35;
      req_valid[0] = 1'b1;
      wait_any_grant(who, gc);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b1;
      wait_rsp(ok);
      chk("bp_rsp_seen", ok, 1);
      chk("bp_result", rsp_result, 16'hEB4C);
      hold_res = rsp_result;
      hold_id  = rsp_id;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid_hold", rsp_valid, 1);
         chk("bp_result_hold", rsp_result, hold_res);
         chk("bp_id_hold", rsp_id, hold_id);
         chk("bp_no_ready", req_ready, 0);
      end
      @(posedge clk);
      #1;
      rsp_ready    = 1'b1;
      req_valid[1] = 1'b0;
      repeat (3) @(posedge clk);

      // Reset mid-RUN at step 4
      #1;
      req_m[0]     = 8'd21;
      req_q[0]     = 8'd13;
      req_valid[0] = 1'b1;
      wait_any_grant(who, gc);
      chk("rst_pre_grant", who, 0);
      repeat (5) @(posedge clk);
      #1;
      req_valid = 2'b00;
      rst_n     = 1'b0;
      #1;
      chk("rst_immediate", {req_ready, rsp_valid, rsp_result, rsp_id, busy}, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 2'b11;
      wait_any_grant(who, gc);
      chk("rst_next_grant", who, 0);
      @(posedge clk);
      #1 req_valid = 2'b00;
      repeat (W + 4) @(posedge clk);

`ifdef BOOTH_SCHED_FLUSH_EN
      #1 req_valid = 2'b01;
      wait_any_grant(who, gc);
      @(posedge clk);
      #1 req_valid = 2'b00;
      repeat (2) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_busy", busy, 0);
      for (int k = 0; k < W + 3; k++) begin
         @(negedge clk);
         chk("flush_no_rsp", rsp_valid, 0);
      end
      @(posedge clk);
      #1 req_valid = 2'b11;
      wait_any_grant(who, gc);
      chk("flush_rr", who, 1);
      @(posedge clk);
      #1 req_valid = 2'b00;
      repeat (W + 4) @(posedge clk);
`endif

      // Random traffic with random back-pressure
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         #1;
         req_valid = N'($urandom);
         for (int r = 0; r < N; r++) begin
            req_m[r] = pick();
            req_q[r] = pick();
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef BOOTH_SCHED_FLUSH_EN
         flush = ($urandom_range(0, 39) == 0);
`endif
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = 1'b1;
`ifdef BOOTH_SCHED_FLUSH_EN
      flush = 1'b0;
`endif
      repeat (W + 4) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/booth_mul_scheduler.md
BOOTH_MUL_SCHEDULER -- requirements
Module: booth_mul_scheduler

Interface
- REQ-001 Parameter DATA_WIDTH, default 8, operand width in bits; legal range 4..32.
- REQ-002 Parameter NUM_REQ, default 2, number of requesters sharing the multiplier; legal range 2..4.
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
- REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
- REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- REQ-007 req_m  input  NUM_REQ x DATA_WIDTH  per-requester signed multiplicand.
- REQ-008 req_q  input  NUM_REQ x DATA_WIDTH  per-requester signed multiplier.
- REQ-009 rsp_valid  output  1  result available.
- REQ-010 rsp_ready  input  1  consumer accepts the result.
- REQ-011 rsp_id  output  clog2(NUM_REQ)  index of the requester that owns the result.
- REQ-012 rsp_result  output  2*DATA_WIDTH  signed product, two's complement.
- REQ-013 busy  output  1  high in any state other than IDLE.

Function
- REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
- REQ-015 In IDLE, the block SHALL grant the first requester with req_valid high, searching round-robin from pointer rr_ptr. It SHALL drive req_ready high for that requester only, in the same cycle (combinational from req_valid).
- REQ-016 On a grant, the block SHALL latch m, q and the requester id, set the accumulator A to 0, q_minus_one to 0 and step_cnt to 0, set rr_ptr to (grantee+1) mod NUM_REQ, and enter RUN.
- REQ-017 A SHALL be DATA_WIDTH+1 bits wide, with m sign-extended, so that m = most-negative value produces a correct product.
- REQ-018 Each RUN cycle SHALL perform exactly one radix-2 Booth step, selected by {Q[0], q_minus_one}:
  - 10: A = A - m.
  - 01: A = A + m.
  - 00 or 11: A unchanged.
  - Then an arithmetic right shift of {A, Q, q_minus_one} by 1, with A's MSB replicated.
- REQ-019 step_cnt SHALL increment each RUN cycle. After step DATA_WIDTH-1 the FSM SHALL enter DONE.
- REQ-020 In DONE, rsp_valid SHALL be 1, and rsp_result = low 2*DATA_WIDTH bits of {A, Q}. rsp_result and rsp_id SHALL be held stable until rsp_ready is high.
- REQ-021 On a rsp_valid && rsp_ready handshake, the FSM SHALL return to IDLE. No new grant SHALL occur in that same cycle.
- REQ-022 Latency: a grant in cycle T SHALL give rsp_valid high in cycle T+DATA_WIDTH+1. Throughput is at most one operation per DATA_WIDTH+2 cycles.
- REQ-023 req_ready SHALL be 0 in RUN and DONE. req_valid changes in those states SHALL have no effect.
- REQ-024 Outside DONE, rsp_valid SHALL be 0 and rsp_result/rsp_id SHALL be 0.

Reset
- REQ-025 While rst_n is low, the block SHALL force state IDLE; A, Q, m, q_minus_one, step_cnt, rr_ptr and the latched id to 0; and all outputs to 0.
- REQ-026 Reset asserted mid-RUN or in DONE SHALL discard the operation with no response. The first grant after reset SHALL begin the search at requester 0.

Configuration
- REQ-027 With macro BOOTH_SCHED_FLUSH_EN defined, the block SHALL add an input port flush (1 bit). flush high in RUN or DONE SHALL return the FSM to IDLE on the next edge and drop the response. rr_ptr SHALL keep its post-grant value. flush in IDLE SHALL suppress grants for that cycle.
- REQ-028 Without BOOTH_SCHED_FLUSH_EN, the flush port and its logic SHALL be absent.

Structure
- REQ-029 Package booth_sched_pkg SHALL hold the state enum type (IDLE/RUN/DONE) and the default DATA_WIDTH and NUM_REQ constants.
- REQ-030 One Booth iteration SHALL be a combinational sub-module booth_step with inputs (A, Q, q_minus_one, m) and the shifted outputs, instantiated once.

Verification
- REQ-031 Requester 0 sends m=7, q=3 -> rsp_result=0x0015, rsp_id=0, rsp_valid exactly 9 cycles after grant.
- REQ-032 m=-128, q=-128 -> rsp_result=0x4000. Also m=127, q=-128 -> 0xC080. Also m=0, q=-1 -> 0x0000.
- REQ-033 Both requesters hold req_valid high for 3 operations -> grants in order 0, 1, 0, with req_ready never high on both bits at once.
- REQ-034 rsp_ready held low 5 cycles in DONE -> rsp_valid, rsp_result and rsp_id stable, and no req_ready asserted.
- REQ-035 rst_n pulsed low at RUN step 4 -> all outputs 0 immediately, state IDLE, and the next grant goes to requester 0.
- REQ-036 With BOOTH_SCHED_FLUSH_EN defined, flush at RUN step 2 -> no rsp_valid, busy=0 next cycle, and the next grant follows rr_ptr.
